// File: rtl/wb_stage.sv
// Writeback stage: one-cycle narrow register writes, and 128-bit wide results
// split into four consecutive 32-bit register writes.
module wb_stage (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         InValid,
    output logic         InReady,
    input  logic         RegWrite,
    input  logic         MemToReg,
    input  logic         Wide,
    input  logic [31:0]  ReadData,
    input  logic [31:0]  ALUResult,
    input  logic [127:0] WD3_128,
    input  logic [4:0]   WriteReg,
    output logic         RF_WE,
    output logic [4:0]   RF_WA,
    output logic [31:0]  RF_WD,
    output logic         Stall,
    output logic [1:0]   Beat
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [1:0]     beat_q, beat_d;
    logic [127:0]   wide_q, wide_d;
    logic [4:0]     base_q, base_d;
    logic           rf_we_q, rf_we_d;
    logic [4:0]     rf_wa_q, rf_wa_d;
    logic [31:0]    rf_wd_q, rf_wd_d;
    logic [1:0]     next_beat;
    logic           accept;

    // Handshake: a result transfers on a rising edge where InValid && InReady.
    // InReady depends on state only; upstream must hold its result while it is low.
    assign InReady = (state_q == IDLE) || (beat_q == 2'd3);
    assign Stall   = ~InReady;
    assign accept  = InValid && InReady;

    always_comb begin
        state_d   = IDLE;
        beat_d    = 2'd0;
        wide_d    = wide_q;
        base_d    = base_q;
        rf_we_d   = 1'b0;
        rf_wa_d   = rf_wa_q;
        rf_wd_d   = rf_wd_q;
        next_beat = beat_q + 2'd1;
        if (accept) begin
            if (Wide && RegWrite) begin
                state_d = BURST;
                wide_d  = WD3_128;
                base_d  = WriteReg;
                rf_wa_d = WriteReg;
                rf_wd_d = WD3_128[31:0];
                rf_we_d = (WriteReg != 5'd0);
            end else begin
                rf_wa_d = WriteReg;
                rf_wd_d = MemToReg ? ReadData : ALUResult;
                rf_we_d = RegWrite && (WriteReg != 5'd0);
            end
        end else if (state_q == BURST && beat_q != 2'd3) begin
            // The 5-bit add wraps the register number modulo 32.
            state_d = BURST;
            beat_d  = next_beat;
            rf_wa_d = base_q + {3'd0, next_beat};
            rf_wd_d = wide_q[{next_beat, 5'd0} +: 32];
            rf_we_d = (rf_wa_d != 5'd0);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            wide_q  <= 128'd0;
            base_q  <= 5'd0;
            rf_we_q <= 1'b0;
            rf_wa_q <= 5'd0;
            rf_wd_q <= 32'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wide_q  <= wide_d;
            base_q  <= base_d;
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
        end
    end

    assign RF_WE = rf_we_q;
    assign RF_WA = rf_wa_q;
    assign RF_WD = rf_wd_q;
    assign Beat  = beat_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected register-file writes are queued when a
// result is driven and compared one per cycle, #1 after the rising edge.
module tb_wb_stage;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         InValid;
    logic         InReady;
    logic         RegWrite;
    logic         MemToReg;
    logic         Wide;
    logic [31:0]  ReadData;
    logic [31:0]  ALUResult;
    logic [127:0] WD3_128;
    logic [4:0]   WriteReg;
    logic         RF_WE;
    logic [4:0]   RF_WA;
    logic [31:0]  RF_WD;
    logic         Stall;
    logic [1:0]   Beat;

    // Expected entry: {we, wa[4:0], wd[31:0], beat[1:0]}
    logic [39:0]  exp_q[$];
    int           checks = 0;
    int           errors = 0;

    wb_stage dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .RegWrite(RegWrite), .MemToReg(MemToReg), .Wide(Wide),
        .ReadData(ReadData), .ALUResult(ALUResult), .WD3_128(WD3_128),
        .WriteReg(WriteReg), .RF_WE(RF_WE), .RF_WA(RF_WA), .RF_WD(RF_WD),
        .Stall(Stall), .Beat(Beat)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [1:0] bt);
        exp_q.push_back({we, wa, wd, bt});
    endtask

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    // Compares the current outputs against the oldest queued write.
    task automatic check_out(input string tag);
        logic [39:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=queue_empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            cmp({tag, ".we"},   {31'd0, RF_WE}, {31'd0, e[39]});
            cmp({tag, ".wa"},   {27'd0, RF_WA}, {27'd0, e[38:34]});
            cmp({tag, ".wd"},   RF_WD,          e[33:2]);
            cmp({tag, ".beat"}, {30'd0, Beat},  {30'd0, e[1:0]});
        end
    endtask

    task automatic check_hs(input string tag, input logic ready);
        cmp({tag, ".ready"}, {31'd0, InReady}, {31'd0, ready});
        cmp({tag, ".stall"}, {31'd0, Stall},   {31'd0, ~ready});
    endtask

    task automatic drive(input logic wide, input logic rw, input logic m2r,
                         input logic [4:0] wr);
        InValid  = 1'b1;
        Wide     = wide;
        RegWrite = rw;
        MemToReg = m2r;
        WriteReg = wr;
    endtask

    logic [127:0] wv;
    logic [31:0]  alu;
    logic [4:0]   reg_r;

    initial begin
        Reset = 1'b1; InValid = 1'b0; RegWrite = 1'b0; MemToReg = 1'b0; Wide = 1'b0;
        ReadData = 32'h0; ALUResult = 32'h0; WD3_128 = '0; WriteReg = 5'd0;

        // Reset state
        tick(); tick();
        Reset = 1'b0;
        push(1'b0, 5'd0, 32'd0, 2'd0);
        check_out("reset");
        check_hs("reset", 1'b1);

        // Narrow load
        drive(1'b0, 1'b1, 1'b1, 5'd5);
        ReadData = 32'hDEADBEEF; ALUResult = $urandom;
        push(1'b1, 5'd5, 32'hDEADBEEF, 2'd0);
        tick(); InValid = 1'b0;
        check_out("narrow_ld");
        tick();
        push(1'b0, 5'd5, 32'hDEADBEEF, 2'd0);
        check_out("narrow_idle");

        // Narrow ALU result
        alu = $urandom; reg_r = 5'($urandom_range(1, 31));
        drive(1'b0, 1'b1, 1'b0, reg_r);
        ALUResult = alu; ReadData = ~alu;
        push(1'b1, reg_r, alu, 2'd0);
        tick(); InValid = 1'b0;
        check_out("narrow_alu");

        // Narrow write to r0 suppressed
        drive(1'b0, 1'b1, 1'b0, 5'd0);
        push(1'b0, 5'd0, alu, 2'd0);
        tick(); InValid = 1'b0;
        check_out("narrow_r0");

        // Wide burst at r8
        drive(1'b1, 1'b1, 1'b1, 5'd8);
        WD3_128 = 128'h44444444_33333333_22222222_11111111;
        push(1'b1, 5'd8,  32'h11111111, 2'd0);
        push(1'b1, 5'd9,  32'h22222222, 2'd1);
        push(1'b1, 5'd10, 32'h33333333, 2'd2);
        push(1'b1, 5'd11, 32'h44444444, 2'd3);
        tick(); InValid = 1'b0;
        check_out("wide_b0"); check_hs("wide_b0", 1'b0);
        tick(); check_out("wide_b1"); check_hs("wide_b1", 1'b0);
        tick(); check_out("wide_b2"); check_hs("wide_b2", 1'b0);
        tick(); check_out("wide_b3"); check_hs("wide_b3", 1'b1);
        tick();
        push(1'b0, 5'd11, 32'h44444444, 2'd0);
        check_out("wide_idle");

        // Wrap at r30 with a narrow held through the burst
        wv = {$urandom, $urandom, $urandom, $urandom};
        drive(1'b1, 1'b1, 1'b0, 5'd30);
        WD3_128 = wv;
        push(1'b1, 5'd30, wv[31:0],   2'd0);
        push(1'b1, 5'd31, wv[63:32],  2'd1);
        push(1'b0, 5'd0,  wv[95:64],  2'd2);
        push(1'b1, 5'd1,  wv[127:96], 2'd3);
        tick();
        alu = $urandom;
        drive(1'b0, 1'b1, 1'b0, 5'd3);
        ALUResult = alu; WD3_128 = ~wv;
        push(1'b1, 5'd3, alu, 2'd0);
        check_out("wrap_b0");
        tick(); check_out("wrap_b1");
        tick(); check_out("wrap_b2");
        tick(); check_out("wrap_b3");
        tick(); InValid = 1'b0;
        check_out("b2b_narrow");
        tick();
        push(1'b0, 5'd3, alu, 2'd0);
        check_out("b2b_idle");

        // Wide followed by a wide held until the beat-3 edge
        wv = {$urandom, $urandom, $urandom, $urandom};
        drive(1'b1, 1'b1, 1'b0, 5'd16);
        WD3_128 = wv;
        for (int k = 0; k < 4; k++) push(1'b1, 5'(16 + k), wv[32*k +: 32], 2'(k));
        tick();
        wv = {$urandom, $urandom, $urandom, $urandom};
        WD3_128 = wv; WriteReg = 5'd20;
        for (int k = 0; k < 4; k++) push(1'b1, 5'(20 + k), wv[32*k +: 32], 2'(k));
        for (int k = 0; k < 4; k++) begin
            check_out("ww_a");
            tick();
        end
        InValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_out("ww_b");
            tick();
        end
        push(1'b0, 5'd23, wv[127:96], 2'd0);
        check_out("ww_idle");
        check_hs("ww_idle", 1'b1);

        // Reset during beat 1 aborts the burst
        wv = {$urandom, $urandom, $urandom, $urandom};
        drive(1'b1, 1'b1, 1'b0, 5'd12);
        WD3_128 = wv;
        push(1'b1, 5'd12, wv[31:0],  2'd0);
        push(1'b1, 5'd13, wv[63:32], 2'd1);
        tick(); InValid = 1'b0;
        check_out("rst_b0");
        tick(); check_out("rst_b1");
        Reset = 1'b1;
        tick(); Reset = 1'b0;
        push(1'b0, 5'd0, 32'd0, 2'd0);
        check_out("rst_abort");
        check_hs("rst_abort", 1'b1);
        tick();
        push(1'b0, 5'd0, 32'd0, 2'd0);
        check_out("rst_after");
        tick();
        cmp("rst_after2.we", {31'd0, RF_WE}, 32'd0);

        // Wide with RegWrite=0: no write, no burst
        drive(1'b1, 1'b0, 1'b0, 5'd7);
        WD3_128 = {$urandom, $urandom, $urandom, $urandom};
        tick(); InValid = 1'b0;
        cmp("nowr.we", {31'd0, RF_WE}, 32'd0);
        check_hs("nowr", 1'b1);
        tick();
        cmp("nowr_next.we", {31'd0, RF_WE}, 32'd0);
        check_hs("nowr_next", 1'b1);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL leftover observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
